ddr3_cpu_traffic_gen: RTL and testbench

DDR3_CPU_TRAFFIC_GEN -- requirements
Module: ddr3_cpu_traffic_gen

---
 rtl/ddr3_cpu_traffic_gen.sv | 154 +++++++++++++++
 tb/tb_ddr3_cpu_traffic_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cpu_traffic_gen.sv
// Row/bank sweep traffic generator for a DDR3 controller CPU port: writes a
// position-derived pattern per row/bank and optionally reads it back to count mismatches.
module ddr3_cpu_traffic_gen #(
  parameter int                ADDR_W        = 15,
  parameter int                BA_W          = 3,
  parameter int                DATA_W        = 64,
  parameter int                WORDS_PER_ROW = 16,
  parameter int                START_ROW     = 0,
  parameter int                STOP_ROW      = 3,
  parameter int                NUM_BANKS     = 1,
  parameter int                MODE          = 1,
  parameter logic [DATA_W-1:0] SEED          = '0
) (
  input  logic              cpu_clk,
  input  logic              RESET_N,
  input  logic              START,
  output logic [ADDR_W-1:0] ADDR,
  output logic [BA_W-1:0]   BA,
  output logic              CMD,
  output logic              ADDR_VALID,
  input  logic              CMD_RDY,
  output logic              WR_READY,
  output logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_DATA_VALID,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic              RD_DATA_VALID,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       ERR_CNT,
  output logic [ADDR_W-1:0] ERR_ROW,
  output logic [BA_W-1:0]   ERR_BA
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_CMD  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_CMD  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  // One extra row bit so a sweep ending at the top row cannot wrap to 0.
  localparam int              RW        = ADDR_W + 1;
  localparam logic [RW-1:0]   FIRST_ROW = RW'(START_ROW);
  localparam logic [RW-1:0]   LAST_ROW  = RW'(STOP_ROW);
  localparam logic [RW-1:0]   ROW_ONE   = RW'(1);
  localparam logic [BA_W-1:0] LAST_BANK = BA_W'(NUM_BANKS - 1);
  localparam logic [BA_W-1:0] BANK_ONE  = BA_W'(1);
  localparam logic [15:0]     LAST_WORD = 16'(WORDS_PER_ROW - 1);
  localparam bit              EMPTY     = (STOP_ROW < START_ROW);

  logic [2:0]        r_state;
  logic [RW-1:0]     r_row;
  logic [BA_W-1:0]   r_bank;
  logic [15:0]       r_word;
  logic              r_done;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_err_row;
  logic [BA_W-1:0]   r_err_ba;

  logic [DATA_W-1:0] w_pat;
  logic              w_last_word;
  logic              w_mismatch;

  assign w_pat       = DATA_W'({r_bank, r_row[ADDR_W-1:0], r_word[7:0]}) ^ SEED;
  assign w_last_word = (r_word == LAST_WORD);
  assign w_mismatch  = (RD_DATA != w_pat);

  assign ADDR       = r_row[ADDR_W-1:0];
  assign BA         = r_bank;
  assign CMD        = (r_state == S_RD_CMD);
  assign ADDR_VALID = (r_state == S_WR_CMD) || (r_state == S_RD_CMD);
  assign WR_READY   = (r_state == S_WR_DATA);
  assign WR_DATA    = WR_READY ? w_pat : '0;
  assign BUSY       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign DONE       = r_done;
  assign ERR_CNT    = r_err_cnt;
  assign ERR_ROW    = r_err_row;
  assign ERR_BA     = r_err_ba;

  always_ff @(posedge cpu_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_bank    <= '0;
      r_word    <= '0;
      r_done    <= 1'b0;
      r_err_cnt <= '0;
      r_err_row <= '0;
      r_err_ba  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_row     <= FIRST_ROW;
            r_bank    <= '0;
            r_word    <= '0;
            r_err_cnt <= '0;
            r_err_row <= '0;
            r_err_ba  <= '0;
            r_done    <= EMPTY;
            r_state   <= EMPTY ? S_FINISH : S_WR_CMD;
          end
        end
        S_WR_CMD: if (CMD_RDY) r_state <= S_WR_DATA;
        S_WR_DATA: begin
          if (WR_DATA_VALID) begin
            if (w_last_word) begin
              r_word  <= '0;
              r_state <= (MODE != 0) ? S_RD_CMD : S_NEXT;
            end else begin
              r_word <= r_word + 16'd1;
            end
          end
        end
        S_RD_CMD: if (CMD_RDY) r_state <= S_RD_DATA;
        S_RD_DATA: begin
          if (RD_DATA_VALID) begin
            if (w_mismatch) begin
              // A zero count means no mismatch yet since START (it saturates, never wraps).
              if (r_err_cnt == 16'd0) begin
                r_err_row <= r_row[ADDR_W-1:0];
                r_err_ba  <= r_bank;
              end
              if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_last_word) begin
              r_word  <= '0;
              r_state <= S_NEXT;
            end else begin
              r_word <= r_word + 16'd1;
            end
          end
        end
        S_NEXT: begin
          if (r_bank != LAST_BANK) begin
            r_bank  <= r_bank + BANK_ONE;
            r_state <= S_WR_CMD;
          end else if (r_row != LAST_ROW) begin
            r_bank  <= '0;
            r_row   <= r_row + ROW_ONE;
            r_state <= S_WR_CMD;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cpu_traffic_gen.sv
// Scoreboard bench: A = write/read-back over rows 0..2 x 2 banks with an echo memory,
// B = write-only single top row (32767). Driver pushes expectations, monitors pop on handshakes.
module tb_ddr3_cpu_traffic_gen;

  localparam logic [63:0] SEED_A = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_start, a_cmd_rdy, a_wdv, a_rdv;
  logic [63:0] a_rd_data;
  logic [14:0] a_addr, a_err_row;
  logic [2:0]  a_ba, a_err_ba;
  logic        a_cmd, a_av, a_wr_ready, a_busy, a_done;
  logic [63:0] a_wr_data;
  logic [15:0] a_err_cnt;

  logic        b_start;
  logic        b_cmd_rdy = 1'b1;
  logic        b_wdv     = 1'b1;
  logic        b_rdv     = 1'b0;
  logic [63:0] b_rd_data = '0;
  logic [14:0] b_addr, b_err_row;
  logic [2:0]  b_ba, b_err_ba;
  logic        b_cmd, b_av, b_wr_ready, b_busy, b_done;
  logic [63:0] b_wr_data;
  logic [15:0] b_err_cnt;

  ddr3_cpu_traffic_gen #(
    .ADDR_W(15), .BA_W(3), .DATA_W(64), .WORDS_PER_ROW(16), .START_ROW(0), .STOP_ROW(2),
    .NUM_BANKS(2), .MODE(1), .SEED(SEED_A)
  ) u_dut_a (
    .cpu_clk(clk), .RESET_N(rst_n), .START(a_start), .ADDR(a_addr), .BA(a_ba), .CMD(a_cmd),
    .ADDR_VALID(a_av), .CMD_RDY(a_cmd_rdy), .WR_READY(a_wr_ready), .WR_DATA(a_wr_data),
    .WR_DATA_VALID(a_wdv), .RD_DATA(a_rd_data), .RD_DATA_VALID(a_rdv), .BUSY(a_busy),
    .DONE(a_done), .ERR_CNT(a_err_cnt), .ERR_ROW(a_err_row), .ERR_BA(a_err_ba)
  );

  ddr3_cpu_traffic_gen #(
    .ADDR_W(15), .BA_W(3), .DATA_W(64), .WORDS_PER_ROW(4), .START_ROW(32767), .STOP_ROW(32767),
    .NUM_BANKS(1), .MODE(0), .SEED(64'h0)
  ) u_dut_b (
    .cpu_clk(clk), .RESET_N(rst_n), .START(b_start), .ADDR(b_addr), .BA(b_ba), .CMD(b_cmd),
    .ADDR_VALID(b_av), .CMD_RDY(b_cmd_rdy), .WR_READY(b_wr_ready), .WR_DATA(b_wr_data),
    .WR_DATA_VALID(b_wdv), .RD_DATA(b_rd_data), .RD_DATA_VALID(b_rdv), .BUSY(b_busy),
    .DONE(b_done), .ERR_CNT(b_err_cnt), .ERR_ROW(b_err_row), .ERR_BA(b_err_ba)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Expected pattern: bank above bit 23, row above bit 8, low byte of word, XOR seed.
  function automatic logic [63:0] pat(input int row, input int bank, input int word,
                                      input logic [63:0] seed);
    return ((64'(bank) << 23) | (64'(row) << 8) | 64'(word & 255)) ^ seed;
  endfunction

  function automatic int mkey(input int row, input int bank, input int word);
    return (bank * 32768 + row) * 16 + word;
  endfunction

  typedef struct packed {
    logic        cmd;
    logic [14:0] addr;
    logic [2:0]  ba;
  } cmd_t;

  cmd_t        a_cmd_q[$];
  logic [63:0] a_wr_q[$];
  cmd_t        b_cmd_q[$];
  logic [63:0] b_wr_q[$];
  logic [63:0] mem[int];

  bit   corrupt = 1'b0;
  bit   a_spur  = 1'b0;
  bit   a_rd_go = 1'b0;
  int   a_wcnt  = 0;
  int   a_cur_row = 0, a_cur_ba = 0;
  int   b_cmd_cnt = 0, b_word_cnt = 0;

  // Monitor A: command/write handshakes, hold stability, handshake-to-data latency.
  bit          a_hold = 1'b0;
  int          a_after = 0;
  logic [14:0] h_addr;
  logic [2:0]  h_ba;
  logic        h_cmd;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_cmd_q.delete();
      a_wr_q.delete();
      a_hold  = 1'b0;
      a_after = 0;
      a_wcnt  = 0;
      a_rd_go = 1'b0;
    end else begin
      check("a_excl", 64'(a_av & a_wr_ready), 64'd0);
      if (a_after == 1) check("a_wr_lat", 64'({a_wr_ready, a_av}), 64'b10);
      else if (a_after == 2) check("a_rd_lat", 64'(a_av), 64'd0);
      a_after = 0;
      if (a_hold) begin
        check("a_hold_av", 64'(a_av), 64'd1);
        check("a_hold_addr", 64'(a_addr), 64'(h_addr));
        check("a_hold_ba", 64'(a_ba), 64'(h_ba));
        check("a_hold_cmd", 64'(a_cmd), 64'(h_cmd));
      end
      a_hold = a_av && !a_cmd_rdy;
      h_addr = a_addr;
      h_ba   = a_ba;
      h_cmd  = a_cmd;
      if (a_av && a_cmd_rdy) begin
        if (a_cmd_q.size() == 0) fail_now("a_cmd_extra");
        else begin
          cmd_t e;
          e = a_cmd_q.pop_front();
          check("a_cmd_type", 64'(a_cmd), 64'(e.cmd));
          check("a_cmd_addr", 64'(a_addr), 64'(e.addr));
          check("a_cmd_ba", 64'(a_ba), 64'(e.ba));
        end
        a_cur_row = int'(a_addr);
        a_cur_ba  = int'(a_ba);
        a_wcnt    = 0;
        a_after   = a_cmd ? 2 : 1;
        if (a_cmd) a_rd_go = 1'b1;
      end
      if (a_wr_ready && a_wdv) begin
        if (a_wr_q.size() == 0) fail_now("a_word_extra");
        else check("a_wr_data", a_wr_data, a_wr_q.pop_front());
        mem[mkey(a_cur_row, a_cur_ba, a_wcnt)] = a_wr_data;
        a_wcnt++;
      end
    end
  end

  // Echo memory for A: one read burst per accepted read command, one idle gap before word 8.
  int a_rd_left = 0, a_rd_idx = 0;
  bit a_gap = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      a_rdv     = 1'b0;
      a_rd_data = '0;
      a_rd_left = 0;
    end else begin
      if (a_rd_go) begin
        a_rd_go   = 1'b0;
        a_rd_left = 16;
        a_rd_idx  = 0;
        a_gap     = 1'b1;
      end
      if (a_rd_left > 0) begin
        if (a_rd_idx == 8 && a_gap) begin
          a_gap = 1'b0;
          a_rdv = 1'b0;
        end else begin
          a_rdv     = 1'b1;
          a_rd_data = mem[mkey(a_cur_row, a_cur_ba, a_rd_idx)] ^
                      ((corrupt && a_cur_row == 2 && a_cur_ba == 1 && a_rd_idx == 5) ? 64'h100 : 64'h0);
          a_rd_idx++;
          a_rd_left--;
        end
      end else if (a_spur) begin
        a_rdv     = 1'b1;
        a_rd_data = '1;
      end else begin
        a_rdv = 1'b0;
      end
    end
  end

  // Monitor B: write-only, tied-high handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_av && b_cmd_rdy) begin
        b_cmd_cnt++;
        if (b_cmd_q.size() == 0) fail_now("b_cmd_extra");
        else begin
          cmd_t e;
          e = b_cmd_q.pop_front();
          check("b_cmd_type", 64'(b_cmd), 64'(e.cmd));
          check("b_cmd_addr", 64'(b_addr), 64'(e.addr));
          check("b_cmd_ba", 64'(b_ba), 64'(e.ba));
        end
      end
      if (b_wr_ready && b_wdv) begin
        b_word_cnt++;
        if (b_wr_q.size() == 0) fail_now("b_word_extra");
        else check("b_wr_data", b_wr_data, b_wr_q.pop_front());
      end
    end
  end

  task automatic push_sweep_a();
    for (int row = 0; row <= 2; row++)
      for (int bank = 0; bank < 2; bank++) begin
        a_cmd_q.push_back('{cmd: 1'b0, addr: 15'(row), ba: 3'(bank)});
        for (int w = 0; w < 16; w++) a_wr_q.push_back(pat(row, bank, w, SEED_A));
        a_cmd_q.push_back('{cmd: 1'b1, addr: 15'(row), ba: 3'(bank)});
      end
  endtask

  task automatic run_a(input bit corr, input bit hold10, input bit abort, output bit aborted);
    corrupt = corr;
    aborted = 1'b0;
    push_sweep_a();
    @(posedge clk); #1;
    a_start   = 1'b1;
    a_cmd_rdy = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_start_lat", 64'({a_av, a_busy, a_done}), 64'b110);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      a_cmd_rdy = !(hold10 && cyc < 10) && (cyc % 4 != 1);
      a_wdv     = (cyc % 3 != 2);
      a_start   = (cyc == 20);
      @(posedge clk); #1;
      if (abort && a_wr_ready && a_wcnt == 7) begin
        aborted = 1'b1;
        break;
      end
      if (a_done) break;
    end
    a_start   = 1'b0;
    a_cmd_rdy = 1'b0;
    a_wdv     = 1'b0;
    if (!aborted && !a_done) fail_now("a_timeout");
  endtask

  task automatic post_a(input int cnt, input int row, input int ba);
    check("a_done", 64'(a_done), 64'd1);
    check("a_busy_end", 64'(a_busy), 64'd0);
    check("a_err_cnt", 64'(a_err_cnt), 64'(cnt));
    check("a_err_row", 64'(a_err_row), 64'(row));
    check("a_err_ba", 64'(a_err_ba), 64'(ba));
    check("a_cmd_left", 64'(a_cmd_q.size()), 64'd0);
    check("a_word_left", 64'(a_wr_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("a_done_sticky", 64'({a_done, a_busy, a_av}), 64'b100);
  endtask

  initial begin
    bit ab;
    rst_n     = 1'b0;
    a_start   = 1'b0;
    a_cmd_rdy = 1'b0;
    a_wdv     = 1'b0;
    b_start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_data", a_wr_data, 64'd0);
    check("a_rst_ctl", 64'({a_addr, a_ba, a_cmd, a_av, a_wr_ready, a_busy, a_done, a_err_cnt,
                            a_err_row, a_err_ba}), 64'd0);
    check("b_rst_ctl", 64'({b_addr, b_ba, b_av, b_wr_ready, b_busy, b_done, b_err_cnt}), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Stray data strobes while idle must not start anything.
    @(posedge clk); #1;
    a_wdv  = 1'b1;
    a_spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_wdv  = 1'b0;
    a_spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("a_idle_ignore", 64'({a_busy, a_av, a_wr_ready, a_done, a_err_cnt}), 64'd0);

    // B: single top row, no wrap to row 0.
    b_cmd_q.push_back('{cmd: 1'b0, addr: 15'd32767, ba: 3'd0});
    for (int w = 0; w < 4; w++) b_wr_q.push_back(64'h0000_0000_007F_FF00 + 64'(w));
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    check("b_start_lat", 64'({b_av, b_addr}), 64'h0_FFFF);
    for (int i = 0; i < 100 && !b_done; i++) begin
      @(posedge clk); #1;
    end
    if (!b_done) fail_now("b_timeout");
    repeat (10) @(posedge clk);
    #1;
    check("b_done", 64'({b_done, b_busy, b_av}), 64'b100);
    check("b_cmd_cnt", 64'(b_cmd_cnt), 64'd1);
    check("b_word_cnt", 64'(b_word_cnt), 64'd4);
    check("b_err_cnt", 64'(b_err_cnt), 64'd0);
    check("b_left", 64'(b_cmd_q.size() + b_wr_q.size()), 64'd0);

    // A: clean sweep with a 10-cycle CMD_RDY stall on the first command.
    run_a(1'b0, 1'b1, 1'b0, ab);
    post_a(0, 0, 0);

    // A: word 5 of row 2 / bank 1 corrupted on read-back.
    run_a(1'b1, 1'b0, 1'b0, ab);
    post_a(1, 2, 1);

    // A: reset during word 7 of the first write burst, then restart from scratch.
    run_a(1'b0, 1'b0, 1'b1, ab);
    if (!ab) fail_now("a_abort_point");
    rst_n = 1'b0;
    #1;
    check("a_rst_mid_data", a_wr_data, 64'd0);
    check("a_rst_mid_ctl", 64'({a_addr, a_ba, a_cmd, a_av, a_wr_ready, a_busy, a_done,
                                a_err_cnt, a_err_row, a_err_ba}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("a_wait_idle", 64'({a_busy, a_av, a_wr_ready}), 64'd0);
    run_a(1'b0, 1'b0, 1'b0, ab);
    post_a(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
